// File: rtl/zircon_avalon_tlc5615_dac_pkg.sv
// Shared types and constants for the TLC5615 DAC Avalon slave.
// Holds the serializer state enum, register addresses and STATUS bit positions.
package zircon_tlc5615_pkg;

    // Serializer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        CS_HIGH  = 2'd3
    } dac_state_e;

    // Avalon register map
    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    // STATUS register bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_PEND = 1;
    localparam int STAT_IRQ  = 2;

    localparam int AVS_DW = 32;
    localparam int CODE_W = 10;

    function automatic logic [AVS_DW-1:0] status_word(
        input logic busy,
        input logic pend,
        input logic irq
    );
        logic [AVS_DW-1:0] w;
        w            = '0;
        w[STAT_BUSY] = busy;
        w[STAT_PEND] = pend;
        w[STAT_IRQ]  = irq;
        return w;
    endfunction

endpackage

// File: rtl/zircon_avalon_tlc5615_dac_if.sv
// Avalon-MM slave bus bundle for the TLC5615 DAC core.
// master: fabric side (address/write/writedata/read out); slave: core side (readdata out).
interface zircon_avalon_tlc5615_dac_if;
    import zircon_tlc5615_pkg::*;

    logic              avs_address;
    logic              avs_write;
    logic [AVS_DW-1:0] avs_writedata;
    logic              avs_read;
    logic [AVS_DW-1:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );

endinterface

// File: rtl/zircon_avalon_tlc5615_dac_serializer.sv
// TLC5615 frame serializer: divider, bit counter, FSM and registered DAC pins.
// Ports: csi_clk/rsi_reset_n, start_valid/start_code (load request), ready, frame_done, busy, cs_n/sclk/din.
module zircon_tlc5615_serializer
    import zircon_tlc5615_pkg::*;
#(
    parameter int CLK_DIV     = 25,
    parameter int CS_HIGH_CYC = 8,
    parameter int FRAME_BITS  = 12
) (
    input  logic              csi_clk,
    input  logic              rsi_reset_n,
    input  logic              start_valid,
    input  logic [CODE_W-1:0] start_code,
    output logic              ready,
    output logic              frame_done,
    output logic              busy,
    output logic              cs_n,
    output logic              sclk,
    output logic              din
);

    localparam int CNT_MAX = (CLK_DIV > CS_HIGH_CYC) ? CLK_DIV : CS_HIGH_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);
    localparam int REM_W   = FRAME_BITS - 1;
    localparam int FILL    = FRAME_BITS - CODE_W;

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CSH_LOAD = CNT_W'(CS_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    dac_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bit_cnt;
    // Bits still to be sent after the one currently on din
    logic [REM_W-1:0] rem;

    // Last CS_HIGH cycle doubles as a load slot so back-to-back frames
    // never pass through IDLE.
    assign frame_done = (state == CS_HIGH) && (cnt == '0);
    assign ready      = (state == IDLE) || frame_done;
    assign busy       = (state != IDLE);

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            rem     <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            din     <= 1'b0;
        end else begin
            case (state)
                IDLE, CS_HIGH: begin
                    if (ready && start_valid) begin
                        state   <= CS_SETUP;
                        cnt     <= DIV_LOAD;
                        bit_cnt <= BIT_LOAD;
                        rem     <= {start_code[CODE_W-2:0], {FILL{1'b0}}};
                        cs_n    <= 1'b0;
                        sclk    <= 1'b0;
                        din     <= start_code[CODE_W-1];
                    end else if (state == CS_HIGH) begin
                        if (frame_done) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                end
                CS_SETUP: begin
                    if (cnt == '0) begin
                        state <= SHIFT;
                        cnt   <= DIV_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (!sclk) begin
                        cnt  <= DIV_LOAD;
                        sclk <= 1'b1;
                    end else begin
                        // Falling edge: advance data, or close the frame
                        sclk <= 1'b0;
                        if (bit_cnt == '0) begin
                            cs_n  <= 1'b1;
                            state <= CS_HIGH;
                            cnt   <= CSH_LOAD;
                        end else begin
                            cnt     <= DIV_LOAD;
                            bit_cnt <= bit_cnt - BIT_ONE;
                            din     <= rem[REM_W-1];
                            rem     <= {rem[REM_W-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/zircon_avalon_tlc5615_dac.sv
// Avalon-MM slave driving a TLC5615 10-bit serial DAC with a one-deep pending buffer.
// Ports: csi_clk, rsi_reset_n, avs (Avalon slave bundle), coe_dac_cs_n/sclk/din,
// ins_irq (only when ZIRCON_TLC5615_IRQ_EN is defined; STATUS bit2 then holds the irq flag).
module zircon_avalon_tlc5615_dac
    import zircon_tlc5615_pkg::*;
#(
    parameter int CLK_DIV     = 25,
    parameter int CS_HIGH_CYC = 8,
    parameter int FRAME_BITS  = 12
) (
    input  logic                        csi_clk,
    input  logic                        rsi_reset_n,
    zircon_avalon_tlc5615_dac_if.slave  avs,
    output logic                        coe_dac_cs_n,
    output logic                        coe_dac_sclk,
    output logic                        coe_dac_din
`ifdef ZIRCON_TLC5615_IRQ_EN
    ,
    output logic                        ins_irq
`endif
);

    logic [CODE_W-1:0] data_reg;
    logic [CODE_W-1:0] pend_reg;
    logic              pending;
    logic              irq_flag;
    logic [AVS_DW-1:0] readdata_q;

    logic              wr_data;
    logic              wr_stat;
    logic [CODE_W-1:0] wr_code;
    logic              start_valid;
    logic [CODE_W-1:0] start_code;
    logic              ready;
    logic              accept;
    logic              frame_done;
    logic              busy;

    assign wr_data = avs.avs_write && (avs.avs_address == ADDR_DATA);
    assign wr_stat = avs.avs_write && (avs.avs_address == ADDR_STATUS);
    assign wr_code = avs.avs_writedata[CODE_W-1:0];

    // A write in the load slot wins over an older pending code
    assign start_valid = wr_data || pending;
    assign start_code  = wr_data ? wr_code : pend_reg;
    assign accept      = ready && start_valid;

    assign avs.avs_readdata = readdata_q;

    zircon_tlc5615_serializer #(
        .CLK_DIV     (CLK_DIV),
        .CS_HIGH_CYC (CS_HIGH_CYC),
        .FRAME_BITS  (FRAME_BITS)
    ) u_ser (
        .csi_clk     (csi_clk),
        .rsi_reset_n (rsi_reset_n),
        .start_valid (start_valid),
        .start_code  (start_code),
        .ready       (ready),
        .frame_done  (frame_done),
        .busy        (busy),
        .cs_n        (coe_dac_cs_n),
        .sclk        (coe_dac_sclk),
        .din         (coe_dac_din)
    );

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            data_reg   <= '0;
            pend_reg   <= '0;
            pending    <= 1'b0;
            readdata_q <= '0;
        end else begin
            if (wr_data) begin
                data_reg <= wr_code;
            end
            if (accept) begin
                pending <= 1'b0;
            end else if (wr_data) begin
                pending  <= 1'b1;
                pend_reg <= wr_code;
            end
            if (avs.avs_read) begin
                if (avs.avs_address == ADDR_STATUS) begin
                    readdata_q <= status_word(busy, pending, irq_flag);
                end else begin
                    readdata_q <= {{(AVS_DW-CODE_W){1'b0}}, data_reg};
                end
            end
        end
    end

`ifdef ZIRCON_TLC5615_IRQ_EN
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            irq_flag <= 1'b0;
        end else if (frame_done) begin
            irq_flag <= 1'b1;
        end else if (wr_stat) begin
            irq_flag <= 1'b0;
        end
    end

    assign ins_irq = irq_flag;
`else
    assign irq_flag = 1'b0;

    logic unused_cfg;
    assign unused_cfg = wr_stat ^ frame_done;
`endif

    logic unused_wdata;
    assign unused_wdata = ^avs.avs_writedata[AVS_DW-1:CODE_W];

endmodule

// File: tb/tb_zircon_avalon_tlc5615_dac.sv
// Testbench for zircon_avalon_tlc5615_dac (CLK_DIV=2, CS_HIGH_CYC=4).
// Frame-timing model checked every cycle plus hand-computed frame/register literals.
module tb_zircon_avalon_tlc5615_dac;

    localparam int D   = 2;
    localparam int H   = 4;
    localparam int NB  = 12;
    localparam int LEN = D * (1 + 2 * NB) + H;

`ifdef ZIRCON_TLC5615_IRQ_EN
    localparam bit          IRQ_ON = 1'b1;
    localparam logic [31:0] IRQ_ST = 32'h4;
`else
    localparam bit          IRQ_ON = 1'b0;
    localparam logic [31:0] IRQ_ST = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n, sclk, din;
`ifdef ZIRCON_TLC5615_IRQ_EN
    logic irq;
`endif

    always #5 clk = ~clk;

    zircon_avalon_tlc5615_dac_if bus();

    zircon_avalon_tlc5615_dac #(
        .CLK_DIV     (D),
        .CS_HIGH_CYC (H),
        .FRAME_BITS  (NB)
    ) dut (
        .csi_clk      (clk),
        .rsi_reset_n  (rst_n),
        .avs          (bus),
        .coe_dac_cs_n (cs_n),
        .coe_dac_sclk (sclk),
        .coe_dac_din  (din)
`ifdef ZIRCON_TLC5615_IRQ_EN
        ,
        .ins_irq      (irq)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic fbit(input logic [9:0] c, input int b);
        logic [11:0] f;
        f = {c, 2'b00};
        return f[b[3:0]];
    endfunction

    // Model state
    int          cyc = 0;
    int          f_start = -1000;
    logic [9:0]  f_code = '0;
    bit          pend_v = 1'b0;
    logic [9:0]  pend_c = '0;
    logic [9:0]  m_data = '0;
    bit          m_irq = 1'b0;
    bit          rd_next = 1'b0;
    logic [31:0] rd_exp = '0;
    // Frame monitor state
    bit          prev_sclk = 1'b0;
    bit          prev_cs = 1'b1;
    logic [11:0] cap = '0;
    int          ncap = 0;
    int          lowcnt = 0;
    logic [11:0] hand_q[$];
    // Compare-process scratch
    int          o, k, b;
    bit          act, done, started;
    logic        e_cs, e_sclk, e_din;
    logic [31:0] stat;
    logic [11:0] hexp;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_cs_n", 32'(cs_n), 32'd1);
                chk("rst_sclk", 32'(sclk), 32'd0);
                chk("rst_din", 32'(din), 32'd0);
                chk("rst_readdata", bus.avs_readdata, 32'd0);
`ifdef ZIRCON_TLC5615_IRQ_EN
                chk("rst_irq", 32'(irq), 32'd0);
`endif
                f_start = -1000;
                pend_v  = 1'b0;
                m_data  = '0;
                m_irq   = 1'b0;
                rd_next = 1'b0;
                ncap    = 0;
                lowcnt  = 0;
                cap     = '0;
            end else begin
                o   = cyc - f_start;
                act = (o >= 0) && (o < LEN);
                e_cs = 1'b1; e_sclk = 1'b0; e_din = 1'b0;
                if (act) begin
                    if (o < D) begin
                        e_cs = 1'b0;
                        e_din = fbit(f_code, NB - 1);
                    end else if (o < D * (1 + 2 * NB)) begin
                        k = (o - D) / D;
                        b = NB - 1 - k / 2;
                        e_cs = 1'b0;
                        e_sclk = (k % 2) == 1;
                        e_din = fbit(f_code, b);
                    end
                end
                chk("pin_cs_n", 32'(cs_n), 32'(e_cs));
                chk("pin_sclk", 32'(sclk), 32'(e_sclk));
                chk("pin_din", 32'(din), 32'(e_din));
`ifdef ZIRCON_TLC5615_IRQ_EN
                chk("pin_irq", 32'(irq), 32'(m_irq));
`endif
                if (rd_next) chk("readdata", bus.avs_readdata, rd_exp);

                if (!cs_n) begin
                    lowcnt++;
                    if (sclk && !prev_sclk) begin
                        cap = {cap[10:0], din};
                        ncap++;
                    end
                end
                if (cs_n && !prev_cs) begin
                    if (hand_q.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        hexp = hand_q.pop_front();
                        chk("frame_bits", 32'(cap), 32'(hexp));
                        chk("frame_sclk_rises", 32'(ncap), 32'd12);
                        chk("frame_cs_low", 32'(lowcnt), 32'd50);
                    end
                    ncap = 0; lowcnt = 0; cap = '0;
                end

                stat = {29'h0, IRQ_ON & m_irq, pend_v, act};
                rd_next = bus.avs_read;
                if (bus.avs_read)
                    rd_exp = bus.avs_address ? stat : {22'h0, m_data};

                done = act && (o == LEN - 1);
                started = 1'b0;
                if (bus.avs_write && !bus.avs_address) begin
                    m_data = bus.avs_writedata[9:0];
                    if (!act || done) begin
                        f_start = cyc + 1;
                        f_code  = bus.avs_writedata[9:0];
                        pend_v  = 1'b0;
                        started = 1'b1;
                    end else begin
                        pend_v = 1'b1;
                        pend_c = bus.avs_writedata[9:0];
                    end
                end
                if (!started && done && pend_v) begin
                    f_start = cyc + 1;
                    f_code  = pend_c;
                    pend_v  = 1'b0;
                end
                if (done) m_irq = 1'b1;
                else if (bus.avs_write && bus.avs_address) m_irq = 1'b0;
            end
            prev_sclk = sclk;
            prev_cs   = cs_n;
            cyc++;
        end
    end

    task automatic wr(input logic a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(posedge clk); #1;
        bus.avs_write = 1'b0;
    endtask

    task automatic rd_chk(input logic a, input logic [31:0] e, input string nm);
        @(posedge clk); #1;
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(posedge clk); #1;
        bus.avs_read = 1'b0;
        chk(nm, bus.avs_readdata, e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int  r;
    bit  ps;

    initial begin
        bus.avs_address   = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_read      = 1'b0;
        rst_n = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("t1_cs_n", 32'(cs_n), 32'd1);
        chk("t1_sclk", 32'(sclk), 32'd0);
        chk("t1_din", 32'(din), 32'd0);
        chk("t1_readdata", bus.avs_readdata, 32'd0);
        rst_n = 1'b1;
        rd_chk(1'b1, 32'h0, "t1_status");

        // Full-scale frame, busy exactly 54 cycles
        hand_q.push_back(12'hFFC);
        wr(1'b0, 32'h3FF);
        repeat (52) @(posedge clk);
        @(posedge clk); #1;
        bus.avs_address = 1'b1;
        bus.avs_read    = 1'b1;
        @(posedge clk); #1;
        chk("t2_busy_last", bus.avs_readdata, 32'h1);
        @(posedge clk); #1;
        bus.avs_read = 1'b0;
        chk("t2_idle_after", bus.avs_readdata, IRQ_ST);

        // Upper write bits ignored
        hand_q.push_back(12'h554);
        wr(1'b0, 32'hFFFF_F155);
        rd_chk(1'b0, 32'h155, "t3_data");
        repeat (60) @(posedge clk);

        // Pending buffer, last write wins
        wr(1'b1, 32'h0);
        hand_q.push_back(12'h004);
        hand_q.push_back(12'h2A8);
        wr(1'b0, 32'h001);
        wr(1'b0, 32'h200);
        wr(1'b0, 32'h0AA);
        rd_chk(1'b1, 32'h3, "t4_status");
        repeat (130) @(posedge clk);
        rd_chk(1'b0, 32'h0AA, "t4_data");

`ifdef ZIRCON_TLC5615_IRQ_EN
        #1;
        chk("t6_irq_set", 32'(irq), 32'd1);
        rd_chk(1'b1, 32'h4, "t6_status");
        wr(1'b1, 32'h0);
        chk("t6_irq_clr", 32'(irq), 32'd0);
`endif

        // Write in the last CS_HIGH cycle chains with no idle gap
        hand_q.push_back(12'hB0C);
        hand_q.push_back(12'h4F0);
        wr(1'b0, 32'h2C3);
        repeat (52) @(posedge clk);
        wr(1'b0, 32'h13C);
        chk("t7_no_gap", 32'(cs_n), 32'd0);
        repeat (120) @(posedge clk);

        // Reset in the middle of a frame
        wr(1'b0, 32'h3FF);
        r  = 0;
        ps = sclk;
        for (int i = 0; i < 200 && r < 5; i++) begin
            @(negedge clk);
            if (sclk && !ps) r++;
            ps = sclk;
        end
        chk("t5_rises", 32'(r), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_cs_n", 32'(cs_n), 32'd1);
        chk("t5_sclk", 32'(sclk), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        rd_chk(1'b1, 32'h0, "t5_status");
        chk("t5_cs_idle", 32'(cs_n), 32'd1);
        chk("frames_seen", 32'(hand_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
